io_input_capture: RTL

Upstream I/O-side producer for the processor's read-only input registers. Samples an external input vector, synchronizes and debounces it, and issues a single write to the clock-domain-crossing register only when the debounced value changes. It respects the crossing's busy handshake. Updates that arrive while a write is in flight are coalesced, so the processor always ends with the newest stable value.

---
 rtl/io_input_capture.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/io_input_capture.sv
// -----------------------------------------------------------------------------
// io_input_capture
//
// I/O-side producer for the processor's read-only input registers. Raw pins
// are synchronized and debounced as one vector. Each newly accepted stable
// value is written once to the clock-domain-crossing register, using its busy
// handshake. A value that becomes stable while an earlier one is still
// waiting replaces it, so the newest stable value is always the one written.
//
// Parameters
//   DATA_WIDTH       width of the pin vector and of the write data
//   RESET_VALUE      reset value of the synchronizer and of the stable value
//                    (must match the downstream register's reset value)
//   SYNC_STAGES      synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES  cycles the synchronized input must hold (>= 2)
//
// Ports
//   IO_Clock    in   I/O clock
//   IO_Reset    in   asynchronous active-low reset
//   Pin_In      in   raw asynchronous input pins
//   IO_WrData   out  write data, held from the strobe until the next write
//   IO_WrEn     out  one-cycle write strobe
//   IO_Busy     in   crossing busy; no write is started while high
//   Drop_Count  out  saturating count of coalesced (overwritten) updates
//
// Build option
//   IO_INPUT_CAPTURE_DROP_COUNT_EN  when defined, Drop_Count is implemented;
//                                   otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module io_input_capture #(
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
    parameter int                    SYNC_STAGES     = 2,
    parameter int                    DEBOUNCE_CYCLES = 1000
) (
    input  logic                  IO_Clock,
    input  logic                  IO_Reset,
    input  logic [DATA_WIDTH-1:0] Pin_In,
    output logic [DATA_WIDTH-1:0] IO_WrData,
    output logic                  IO_WrEn,
    input  logic                  IO_Busy,
    output logic [7:0]            Drop_Count
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DATA_WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] candidate;
    logic [DATA_WIDTH-1:0] stable;
    logic [DATA_WIDTH-1:0] latch;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [CNT_W-1:0]      deb_cnt;
    logic                  pending;
    logic                  stable_upd;
    logic                  start_wr;
    logic                  wr_en_q;
    logic                  wr_en_nxt;
    state_t                state;
    state_t                state_nxt;

    // Synchronizer: stage 0 samples the pins, the last stage feeds debounce.
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= RESET_VALUE;
            end
        end else begin
            sync_p[0] <= Pin_In;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign sync = sync_p[SYNC_STAGES-1];

    // Debounce: any change of the whole vector restarts the hold count. The
    // acceptance test uses the pre-edge counter, so it is independent of
    // whether sync changes on the same edge.
    assign stable_upd = (deb_cnt == CNT_MAX) && (candidate != stable);

    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            candidate <= RESET_VALUE;
            deb_cnt   <= '0;
            stable    <= RESET_VALUE;
        end else begin
            if (sync != candidate) begin
                candidate <= sync;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= sat_inc_cnt(deb_cnt);
            end
            if (stable_upd) begin
                stable <= candidate;
            end
        end
    end

    // Pending write slot. A new stable value always wins over clearing, so an
    // update landing on the same edge as a write start stays queued.
    assign start_wr = (state == ST_IDLE) && pending && !IO_Busy;

    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            pending <= 1'b0;
        end else if (stable_upd) begin
            pending <= 1'b1;
        end else if (start_wr) begin
            pending <= 1'b0;
        end
    end

    // Only meaningful while pending is set, so it needs no reset.
    always_ff @(posedge IO_Clock) begin
        if (stable_upd) begin
            latch <= candidate;
        end
    end

    // Write FSM: state register.
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM: next state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start_wr) state_nxt = ST_WRITE;
            ST_WRITE:     state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (IO_Busy) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!IO_Busy) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Write FSM: outputs, registered so the strobe is glitch-free and aligned
    // exactly with the WRITE state.
    always_comb begin
        wr_en_nxt = (state_nxt == ST_WRITE);
    end

    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= RESET_VALUE;
        end else begin
            wr_en_q <= wr_en_nxt;
            if (start_wr) begin
                wr_data_q <= latch;
            end
        end
    end

    assign IO_WrEn   = wr_en_q;
    assign IO_WrData = wr_data_q;

`ifdef IO_INPUT_CAPTURE_DROP_COUNT_EN
    // A drop is an overwrite of a value that will never be written; the
    // same-edge write start case still writes the old value, so no drop.
    logic [7:0] drop_cnt;

    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            drop_cnt <= 8'd0;
        end else if (stable_upd && pending && !start_wr) begin
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    assign Drop_Count = drop_cnt;
`else
    assign Drop_Count = 8'd0;
`endif

endmodule
